// File: rtl/randomnum.sv
// Pseudo-random mole selector: a free-running 8-bit LFSR picks one of 8 positions each hold period.
// Latency: one cycle from the first EN=1 edge to a lit mole; a new mole every HOLD_CYCLES cycles.
// Backpressure: none. EN=0 blanks the output at the next edge and aborts any hold in progress.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst      - synchronous active-low reset (0 = reset), overrides EN
//   EN       - active-high enable for mole selection
//   data_out - active-low one-hot mole select, 8'hFF when no mole is lit
//
// Parameters:
//   SEED        - LFSR reset value; 0 is replaced by 8'h01 (0 is the lock-up state)
//   HOLD_CYCLES - cycles each mole stays lit, 1..65535
//
// Build option:
//   RANDOMNUM_NO_REPEAT_EN - when defined, a selection that would land on the previous
//   position is bumped to the next one (mod 8), so continuous play never repeats a mole.

module randomnum #(
  parameter logic [7:0] SEED        = 8'h01,
  parameter int         HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  output logic [7:0] data_out
);

  // All-zero is the one state a XOR-feedback LFSR can never leave.
  localparam logic [7:0]  SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

`ifdef RANDOMNUM_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic        fb;
  logic [15:0] cnt;
  logic [2:0]  prev_idx;
  logic [2:0]  sel_idx;
  logic        repeat_hit;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (maximal length, period 255).
  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    lfsr_next = {lfsr[6:0], fb};
    // Lock-up guard: should the register ever hold zero, restart the sequence.
    if (lfsr == 8'h00) begin
      lfsr_next = 8'h01;
    end
  end

  // Selection uses the pre-shift LFSR value at the select edge.
  assign repeat_hit = (lfsr[2:0] == prev_idx);

  always_comb begin
    sel_idx = lfsr[2:0];
    if (NO_REPEAT && repeat_hit) begin
      sel_idx = lfsr[2:0] + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr     <= SEED_EFF;
      cnt      <= 16'd0;
      prev_idx <= 3'd0;
      data_out <= 8'hFF;
    end else begin
      // LFSR free-runs regardless of EN.
      lfsr <= lfsr_next;
      if (!EN) begin
        // Dropping EN blanks the output and clears the hold, so the next
        // enabled edge selects immediately with a fresh full hold.
        data_out <= 8'hFF;
        cnt      <= 16'd0;
      end else if (cnt == 16'd0) begin
        data_out <= ~(8'b0000_0001 << sel_idx);
        prev_idx <= sel_idx;
        cnt      <= HOLD_RELOAD;
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_randomnum.sv
module tb_randomnum;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] q0, q1, q2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  randomnum #(.SEED(8'h01), .HOLD_CYCLES(10)) u0 (.clk(clk), .rst(rst), .EN(en), .data_out(q0));
  randomnum #(.SEED(8'h00), .HOLD_CYCLES(1))  u1 (.clk(clk), .rst(rst), .EN(en), .data_out(q1));
  randomnum #(.SEED(8'hA5), .HOLD_CYCLES(3))  u2 (.clk(clk), .rst(rst), .EN(en), .data_out(q2));

`ifdef RANDOMNUM_NO_REPEAT_EN
  localparam bit NO_REP = 1'b1;
`else
  localparam bit NO_REP = 1'b0;
`endif

  // ---------------- reference model ----------------
  // The maximal-length sequence starting at 8'h01; each instance is a fixed
  // offset into it, and the state after k shifts is base[(off+k) % 255].
  logic [7:0] base [255];
  int         off_m  [3];
  int         hold_m [3] = '{10, 1, 3};
  int         k_m    [3];   // shifts since reset
  int         run_m  [3];   // consecutive enabled edges since reset / EN low
  logic [2:0] prev_m [3];
  logic [7:0] out_m  [3];

  typedef struct packed {
    logic [2:0][7:0] out;
    logic [2:0][7:0] lf;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic build_model();
    logic [7:0] s;
    base[0] = 8'h01;
    for (int j = 1; j < 255; j++) begin
      s = base[j-1];
      base[j] = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    off_m[0] = 0;
    off_m[1] = 0;
    off_m[2] = 0;
    for (int j = 0; j < 255; j++) if (base[j] == 8'hA5) off_m[2] = j;
  endtask

  // One clock edge seen by the model with the inputs that were applied.
  task automatic model_edge(input logic r, input logic e);
    exp_t x;
    logic [7:0] l;
    logic [2:0] idx;
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        k_m[i] = 0; run_m[i] = 0; prev_m[i] = 3'd0; out_m[i] = 8'hFF;
      end else begin
        l = base[(off_m[i] + k_m[i]) % 255];
        k_m[i]++;
        if (e) begin
          // A new mole at the start of every HOLD-long window of enabled edges.
          if (run_m[i] % hold_m[i] == 0) begin
            idx = l[2:0];
            if (NO_REP && idx == prev_m[i]) idx = idx + 3'd1;
            out_m[i] = 8'hFF;
            out_m[i][idx] = 1'b0;
            prev_m[i] = idx;
          end
          run_m[i]++;
        end else begin
          out_m[i] = 8'hFF;
          run_m[i] = 0;
        end
      end
      x.out[i] = out_m[i];
      x.lf[i]  = base[(off_m[i] + k_m[i]) % 255];
    end
    sb.push_back(x);
  endtask

  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    model_edge(r, e);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic [7:0] seen1 = 8'h00;
  logic [7:0] last1 = 8'hFF;
  int         reps1 = 0;

  function automatic logic onehot_low(input logic [7:0] v);
    return (v == 8'hFF) || ($countones(~v) == 1);
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("u0_out",  q0, x.out[0]);
      chk("u1_out",  q1, x.out[1]);
      chk("u2_out",  q2, x.out[2]);
      chk("u0_lfsr", u0.lfsr, x.lf[0]);
      chk("u1_lfsr", u1.lfsr, x.lf[1]);
      chk("u2_lfsr", u2.lfsr, x.lf[2]);
      chk("u1_onehot", {7'd0, onehot_low(q1)}, 8'd1);
      chk("u2_onehot", {7'd0, onehot_low(q2)}, 8'd1);
      if (q1 != 8'hFF) begin
        seen1 = seen1 | ~q1;
        if (q1 == last1) reps1++;
      end
      last1 = q1;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] seq0 [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
  logic [7:0] first_sel;

  initial begin
    build_model();
    first_sel = NO_REP ? 8'hFD : 8'hFE;

    // Reset, then walk the start of the sequence with EN low.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    chk("rst_out", q0, 8'hFF);
    chk("rst_lfsr", u0.lfsr, seq0[0]);
    chk("seed0_lfsr", u1.lfsr, 8'h01);
    for (int j = 1; j < 4; j++) begin
      step(1'b1, 1'b0);
      @(negedge clk);
      chk("seq_lfsr", u0.lfsr, seq0[j]);
    end
    // Select edge sees lfsr=08 -> position 0.
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("first_sel", q0, first_sel);
    chk("seq_lfsr", u0.lfsr, seq0[4]);

    // Idle for a full period: output stays blank, LFSR returns to the seed.
    step(1'b0, 1'b0);
    for (int j = 0; j < 255; j++) step(1'b1, 1'b0);
    @(negedge clk);
    chk("period_lfsr", u0.lfsr, 8'h01);
    chk("idle_out", q0, 8'hFF);

    // Continuous enable, then a 1-cycle drop at hold cycle 4.
    for (int j = 0; j < 24; j++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    @(negedge clk);
    chk("drop_out", q0, 8'hFF);
    for (int j = 0; j < 25; j++) step(1'b1, 1'b1);

    // Reset while a mole is lit.
    for (int j = 0; j < 3; j++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    chk("midrst_out", q0, 8'hFF);
    chk("midrst_lfsr", u0.lfsr, 8'h01);
    chk("midrst_cnt", u0.cnt[7:0], 8'h00);

    // Long continuous run: every position should appear on the HOLD=1 unit.
    for (int j = 0; j < 600; j++) step(1'b1, 1'b1);

    // Random EN with occasional reset.
    for (int j = 0; j < 1500; j++)
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7));

    step(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 8'(sb.size()), 8'd0);
    chk("u1_all_pos", seen1, 8'hFF);
    if (NO_REP) chk("u1_no_repeat", 8'(reps1), 8'd0);
    else        chk("u1_repeats_seen", {7'd0, reps1 > 0}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, want finish");
    $fatal(1, "timeout");
  end

endmodule
